// File: rtl/cw305_crypto_ctrl.sv
// Crypto-core launch controller for a CW305-style target.
//
// Accepts a start request with key/plaintext/target core, optionally waits a
// programmable pre-delay, strobes the selected core's load line, times the
// core's busy window and captures its ciphertext.
//
// Ports:
//   clk, rst              single clock, asynchronous active-high reset
//   start_i               one-cycle launch request (honoured only in IDLE)
//   core_sel_i            target core index
//   key_i, text_i         key and plaintext, latched on accept
//   trig_dly_i            cycles spent in DELAY between accept and load
//   timeout_i             RUN timeout in cycles, 0 disables
//   core_load_o           one-hot load strobe (one cycle)
//   core_key_o/_text_o    latched key/plaintext shared by all cores
//   core_busy_i           per-core busy
//   core_ct_i             per-core ciphertext, core k at [k*pCT_WIDTH +: pCT_WIDTH]
//   ct_o                  captured ciphertext
//   done_o                one-cycle completion pulse
//   busy_o                high whenever not IDLE
//   trigger_o             scope trigger, high from LOAD through the last RUN cycle
//   timeout_o, sel_err_o  sticky status flags, cleared by the next accept
//   cycles_o              RUN cycle count of the last operation
module cw305_crypto_ctrl #(
    parameter int pNUM_CORES = 4,
    parameter int pPT_WIDTH  = 128,
    parameter int pKEY_WIDTH = 128,
    parameter int pCT_WIDTH  = 128,
    parameter int pCNT_WIDTH = 32,
    parameter int pDLY_WIDTH = 8,
    parameter int pSEL_WIDTH = (pNUM_CORES > 1) ? $clog2(pNUM_CORES) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_i,
    input  logic [pSEL_WIDTH-1:0]           core_sel_i,
    input  logic [pKEY_WIDTH-1:0]           key_i,
    input  logic [pPT_WIDTH-1:0]            text_i,
    input  logic [pDLY_WIDTH-1:0]           trig_dly_i,
    input  logic [pCNT_WIDTH-1:0]           timeout_i,
    output logic [pNUM_CORES-1:0]           core_load_o,
    output logic [pKEY_WIDTH-1:0]           core_key_o,
    output logic [pPT_WIDTH-1:0]            core_text_o,
    input  logic [pNUM_CORES-1:0]           core_busy_i,
    input  logic [pNUM_CORES*pCT_WIDTH-1:0] core_ct_i,
    output logic [pCT_WIDTH-1:0]            ct_o,
    output logic                            done_o,
    output logic                            busy_o,
    output logic                            trigger_o,
    output logic                            timeout_o,
    output logic                            sel_err_o,
    output logic [pCNT_WIDTH-1:0]           cycles_o
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StDelay   = 3'd1;
    localparam logic [2:0] StLoad    = 3'd2;
    localparam logic [2:0] StRun     = 3'd3;
    localparam logic [2:0] StCapture = 3'd4;

    // One extra bit so pNUM_CORES itself is representable for the range check.
    localparam logic [pSEL_WIDTH:0] NumCores = (pSEL_WIDTH + 1)'(pNUM_CORES);

    logic [2:0]            state_q, state_d;
    logic [pKEY_WIDTH-1:0] key_q;
    logic [pPT_WIDTH-1:0]  text_q;
    logic [pSEL_WIDTH-1:0] sel_q, sel_d;
    logic [pDLY_WIDTH-1:0] dly_cnt_q;
    logic                  seen_q;
    logic [pNUM_CORES-1:0] load_q, load_d;
    logic [pCT_WIDTH-1:0]  ct_q, ct_sel;
    logic                  done_q;
    logic                  trig_q;
    logic                  tmo_q;
    logic                  sel_err_q;
    logic [pCNT_WIDTH-1:0] cycles_q, cycles_inc;

    logic sel_valid;
    logic accept;
    logic busy_sel;
    logic busy_fall;
    logic timeout_hit;

    assign sel_valid = ({1'b0, core_sel_i} < NumCores);
    assign accept    = (state_q == StIdle) && start_i && sel_valid;
    assign sel_d     = accept ? core_sel_i : sel_q;

    // Select the latched core's busy and ciphertext without indexing past pNUM_CORES.
    always_comb begin
        busy_sel = 1'b0;
        ct_sel   = '0;
        for (int k = 0; k < pNUM_CORES; k++) begin
            if (sel_q == pSEL_WIDTH'(k)) begin
                busy_sel = core_busy_i[k];
                ct_sel   = core_ct_i[k*pCT_WIDTH +: pCT_WIDTH];
            end
        end
    end

    // Busy must have been seen high in an earlier RUN cycle before a low counts as done.
    assign busy_fall   = seen_q && !busy_sel;
    assign cycles_inc  = (cycles_q == '1) ? cycles_q : cycles_q + 1'b1;
    assign timeout_hit = (timeout_i != '0) && (cycles_inc >= timeout_i);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (trig_dly_i != '0) ? StDelay : StLoad;
                end
            end
            StDelay: begin
                if (dly_cnt_q <= 1) begin
                    state_d = StLoad;
                end
            end
            StLoad:  state_d = StRun;
            StRun: begin
                if (busy_fall) begin
                    state_d = StCapture;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end
            end
            StCapture: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        load_d = '0;
        for (int k = 0; k < pNUM_CORES; k++) begin
            load_d[k] = (state_d == StLoad) && (sel_d == pSEL_WIDTH'(k));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            key_q     <= '0;
            text_q    <= '0;
            sel_q     <= '0;
            dly_cnt_q <= '0;
            seen_q    <= 1'b0;
            load_q    <= '0;
            ct_q      <= '0;
            done_q    <= 1'b0;
            trig_q    <= 1'b0;
            tmo_q     <= 1'b0;
            sel_err_q <= 1'b0;
            cycles_q  <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            done_q  <= (state_d == StCapture);
            trig_q  <= (state_d == StLoad) || (state_d == StRun);

            if (accept) begin
                key_q     <= key_i;
                text_q    <= text_i;
                sel_q     <= core_sel_i;
                dly_cnt_q <= trig_dly_i;
                seen_q    <= 1'b0;
                tmo_q     <= 1'b0;
                sel_err_q <= 1'b0;
                cycles_q  <= '0;
            end else if ((state_q == StIdle) && start_i) begin
                sel_err_q <= 1'b1;
            end

            if (state_q == StDelay) begin
                dly_cnt_q <= dly_cnt_q - 1'b1;
            end

            if (state_q == StRun) begin
                cycles_q <= cycles_inc;
                if (busy_sel) begin
                    seen_q <= 1'b1;
                end
                if (busy_fall) begin
                    ct_q <= ct_sel;
                end else if (timeout_hit) begin
                    tmo_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign core_key_o  = key_q;
    assign core_text_o = text_q;
    assign core_load_o = load_q;
    assign ct_o        = ct_q;
    assign done_o      = done_q;
    assign trigger_o   = trig_q;
    assign timeout_o   = tmo_q;
    assign sel_err_o   = sel_err_q;
    assign cycles_o    = cycles_q;

endmodule
